// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, segment constants and helpers for the seven-segment driver
//
// Purpose: FSM state type, active-low segment constants, nibble decoder and
// leading-zero blanking mask used by seg7_multi_digit_driver.
// Ports: none (package).
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    UPDATE  = 2'd2
  } state_t;

  localparam int MAX_DIGITS = 8;

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_BLANK_AL = 7'b1111111;
  localparam logic [6:0] SEG_DASH_AL  = 7'b0111111;

  function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0011000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Bit i set when digit i and every digit above it are zero. Digit 0 is
  // never blanked so a zero value still shows "0".
  function automatic logic [MAX_DIGITS-1:0] lead_blank_mask(input logic [4*MAX_DIGITS-1:0] digits);
    logic [MAX_DIGITS-1:0] m;
    logic                  seen;
    m    = '0;
    seen = 1'b0;
    for (int i = MAX_DIGITS - 1; i >= 1; i--) begin
      seen = seen | (digits[4*i +: 4] != 4'h0);
      m[i] = ~seen;
    end
    return m;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to BCD converter
//
// Purpose: converts DATA_W-bit unsigned din into N_DIGITS BCD digits, one
// shift per clock, DATA_W shift cycles after the start cycle.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   start, din  - load din and begin converting (ignored while busy)
//   busy        - shifts are in progress
//   done        - high during the final shift cycle; bcd/ovf are valid
//                 from the following cycle until the next start
//   bcd, ovf    - result digits; ovf set if a 1 left the top digit
module bin2bcd_seq #(
  parameter int DATA_W   = 16,
  parameter int N_DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     din,
  output logic                  busy,
  output logic                  done,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic                  ovf
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] sh;
  logic [CNT_W-1:0]  cnt;
  logic [BCD_W-1:0]  adj;

  assign busy = (cnt != '0);
  assign done = (cnt == CNT_W'(1));

  // Add-3 correction applied before each shift.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      sh  <= '0;
      bcd <= '0;
      ovf <= 1'b0;
    end else if (start && !busy) begin
      cnt <= CNT_W'(DATA_W);
      sh  <= din;
      bcd <= '0;
      ovf <= 1'b0;
    end else if (busy) begin
      bcd <= {adj[BCD_W-2:0], sh[DATA_W-1]};
      ovf <= ovf | adj[BCD_W-1];
      sh  <= {sh[DATA_W-2:0], 1'b0};
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg7_multi_digit_driver.sv
// rtl/seg7_multi_digit_driver.sv - N-digit seven-segment driver, hex or decimal
//
// Purpose: accepts a value over a valid/ready handshake and renders it on
// N_DIGITS seven-segment digits in hex or decimal, with optional leading-zero
// blanking and dash display on overflow.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   in_data, in_valid   - value and request; accepted when in_ready is high
//   in_ready            - high only while idle
//   mode_dec, blank_lz  - decimal mode / blank leading zeros, sampled at accept
//   seg                 - digit i on seg[7i+6:7i], {g,f,e,d,c,b,a}
//   done                - one-cycle pulse on the first cycle new seg is shown
//   ovf                 - value did not fit in N_DIGITS, updated with seg
module seg7_multi_digit_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS   = 6,
  parameter int DATA_W     = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode_dec,
  input  logic                  blank_lz,
  output logic [7*N_DIGITS-1:0] seg,
  output logic                  done,
  output logic                  ovf
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int EXT_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;
  localparam logic [6:0] SEG_OFF = (ACTIVE_LOW != 0) ? SEG_BLANK_AL : ~SEG_BLANK_AL;

  state_t state, state_next;

  logic              accept;
  logic [DATA_W-1:0] data_q;
  logic              mode_q;
  logic              blz_q;

  logic              bcd_busy;
  logic              bcd_done;
  logic [BCD_W-1:0]  bcd;
  logic              bcd_ovf;

  logic [EXT_W-1:0]      hex_ext;
  logic                  hex_ovf;
  logic [BCD_W-1:0]      digits_sel;
  logic                  ovf_sel;
  logic [N_DIGITS-1:0]   lz_mask;
  logic [6:0]            pat;
  logic [7*N_DIGITS-1:0] seg_next;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  bin2bcd_seq #(
    .DATA_W   (DATA_W),
    .N_DIGITS (N_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (accept && mode_dec),
    .din   (in_data),
    .busy  (bcd_busy),
    .done  (bcd_done),
    .bcd   (bcd),
    .ovf   (bcd_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = mode_dec ? CONVERT : UPDATE;
      // The converter flags its final shift, so UPDATE starts the cycle
      // after the last shift lands. Losing busy without done only happens
      // if the converter was knocked out of step; fall back to idle.
      CONVERT: begin
        if (bcd_done)       state_next = UPDATE;
        else if (!bcd_busy) state_next = IDLE;
      end
      UPDATE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Hex digits: zero-extend the captured value; any bit beyond the last
  // displayable nibble is an overflow.
  assign hex_ext    = EXT_W'(data_q);
  assign hex_ovf    = |(hex_ext >> BCD_W);
  assign digits_sel = mode_q ? bcd : hex_ext[BCD_W-1:0];
  assign ovf_sel    = mode_q ? bcd_ovf : hex_ovf;
  assign lz_mask    = N_DIGITS'(lead_blank_mask((4*MAX_DIGITS)'(digits_sel)));

  always_comb begin
    pat      = SEG_BLANK_AL;
    seg_next = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (ovf_sel)                 pat = SEG_DASH_AL;
      else if (blz_q && lz_mask[i]) pat = SEG_BLANK_AL;
      else                         pat = nibble_to_seg(digits_sel[4*i +: 4]);
      seg_next[7*i +: 7] = (ACTIVE_LOW != 0) ? pat : ~pat;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg    <= {N_DIGITS{SEG_OFF}};
      done   <= 1'b0;
      ovf    <= 1'b0;
      data_q <= '0;
      mode_q <= 1'b0;
      blz_q  <= 1'b0;
    end else begin
      done <= (state == UPDATE);
      if (accept) begin
        data_q <= in_data;
        mode_q <= mode_dec;
        blz_q  <= blank_lz;
      end
      if (state == UPDATE) begin
        seg <= seg_next;
        ovf <= ovf_sel;
      end
    end
  end

endmodule
